// File: rtl/gpu_fb_pkg.sv
// Shared framebuffer geometry, bus widths, colour constants and arbiter bus-owner states.
package gpu_fb_pkg;

    localparam int unsigned FB_COLS  = 640;
    localparam int unsigned FB_ROWS  = 400;
    localparam int unsigned FB_WORDS = FB_COLS * FB_ROWS;
    localparam int unsigned ADDR_W   = 18;
    localparam int unsigned DATA_W   = 16;

    localparam logic [DATA_W-1:0] WHITE = 16'hFFFF;
    localparam logic [DATA_W-1:0] BLUE  = 16'h00FF;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        TURN,
        WR
    } arb_state_t;

endpackage

// File: rtl/fb_sram_arbiter_if.sv
// Pixel-write, scan-out and SRAM bus bundle; slave is the arbiter's view, master the surroundings'.
interface fb_sram_arbiter_if #(
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DATA_W = 16
);

    logic              I_PIX_VALID;
    logic [ADDR_W-1:0] I_PIX_ADDR;
    logic [DATA_W-1:0] I_PIX_DATA;
    logic              O_PIX_READY;
    logic              I_VGA_READ;
    logic [ADDR_W-1:0] I_VGA_ADDR;
    logic [DATA_W-1:0] O_VGA_DATA;
    logic              O_VGA_DATA_VALID;
    logic [ADDR_W-1:0] O_SRAM_ADDR;
    logic [DATA_W-1:0] O_SRAM_DATA;
    logic [DATA_W-1:0] I_SRAM_DATA;
    logic              O_SRAM_READ;
    logic              O_SRAM_WRITE;
    logic [15:0]       O_DROP_CNT;

    modport slave (
        input  I_PIX_VALID, I_PIX_ADDR, I_PIX_DATA, I_VGA_READ, I_VGA_ADDR, I_SRAM_DATA,
        output O_PIX_READY, O_VGA_DATA, O_VGA_DATA_VALID, O_SRAM_ADDR, O_SRAM_DATA,
               O_SRAM_READ, O_SRAM_WRITE, O_DROP_CNT
    );

    modport master (
        output I_PIX_VALID, I_PIX_ADDR, I_PIX_DATA, I_VGA_READ, I_VGA_ADDR, I_SRAM_DATA,
        input  O_PIX_READY, O_VGA_DATA, O_VGA_DATA_VALID, O_SRAM_ADDR, O_SRAM_DATA,
               O_SRAM_READ, O_SRAM_WRITE, O_DROP_CNT
    );

endinterface

// File: rtl/pixel_fifo.sv
// Synchronous FIFO of {addr, data} pixel-write entries; DEPTH must be a power of two.
module pixel_fifo #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 34,
    localparam int unsigned PtrW  = $clog2(DEPTH),
    localparam int unsigned CntW  = PtrW + 1
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge I_CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fb_sram_arbiter.sv
// Framebuffer SRAM arbiter: VGA reads own the bus with fixed latency, queued GPU writes fill gaps.
// Define PIX_CLIP_EN to accept-but-drop pixels addressed at or beyond FB_WORDS and count them.
module fb_sram_arbiter
    import gpu_fb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = gpu_fb_pkg::ADDR_W,
    parameter int unsigned DATA_W     = gpu_fb_pkg::DATA_W
`ifdef PIX_CLIP_EN
    ,
    parameter int unsigned FB_WORDS   = gpu_fb_pkg::FB_WORDS
`endif
) (
    input logic              I_CLK,
    input logic              I_RST,
    fb_sram_arbiter_if.slave bus
);

    localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned FifoW = ADDR_W + DATA_W;

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_wdata_q, sram_wdata_d;
    logic              sram_read_q, sram_read_d;
    logic              sram_write_q, sram_write_d;
    logic [DATA_W-1:0] vga_data_q;
    logic              vga_valid_q;
    logic              ready_en_q;

    logic              pix_ready;
    logic              pix_accept;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FifoW-1:0]  fifo_rdata;
    logic [CntW-1:0]   fifo_count;

    // Ready stays low for the cycle following any reset edge.
    assign pix_ready  = ready_en_q && !fifo_full;
    assign pix_accept = bus.I_PIX_VALID && pix_ready;

`ifdef PIX_CLIP_EN
    logic        pix_in_fb;
    logic [15:0] drop_cnt_q;

    assign pix_in_fb = (32'(bus.I_PIX_ADDR) < FB_WORDS);
    assign fifo_push = pix_accept && pix_in_fb;

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            drop_cnt_q <= '0;
        end else if (pix_accept && !pix_in_fb && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.O_DROP_CNT = drop_cnt_q;
`else
    assign fifo_push      = pix_accept;
    assign bus.O_DROP_CNT = 16'h0;
`endif

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FifoW)
    ) u_pixel_fifo (
        .I_CLK   (I_CLK),
        .I_RST   (I_RST),
        .push_i  (fifo_push),
        .wdata_i ({bus.I_PIX_ADDR, bus.I_PIX_DATA}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // State names the bus owner for the coming cycle; a read request always wins.
    always_comb begin
        state_d      = IDLE;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_read_d  = 1'b0;
        sram_write_d = 1'b0;
        fifo_pop     = 1'b0;
        if (bus.I_VGA_READ) begin
            state_d     = RD;
            sram_addr_d = bus.I_VGA_ADDR;
            sram_read_d = 1'b1;
        end else begin
            unique case (state_q)
                RD: state_d = TURN;
                IDLE, TURN, WR: begin
                    if (!fifo_empty) begin
                        state_d      = WR;
                        fifo_pop     = 1'b1;
                        sram_addr_d  = fifo_rdata[FifoW-1-:ADDR_W];
                        sram_wdata_d = fifo_rdata[DATA_W-1:0];
                        sram_write_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q      <= IDLE;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_read_q  <= 1'b0;
            sram_write_q <= 1'b0;
            vga_data_q   <= '0;
            vga_valid_q  <= 1'b0;
            ready_en_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_read_q  <= sram_read_d;
            sram_write_q <= sram_write_d;
            vga_valid_q  <= sram_read_q;
            ready_en_q   <= 1'b1;
            if (sram_read_q) vga_data_q <= bus.I_SRAM_DATA;
        end
    end

    assign bus.O_PIX_READY      = pix_ready;
    assign bus.O_VGA_DATA       = vga_data_q;
    assign bus.O_VGA_DATA_VALID = vga_valid_q;
    assign bus.O_SRAM_ADDR      = sram_addr_q;
    assign bus.O_SRAM_DATA      = sram_wdata_q;
    assign bus.O_SRAM_READ      = sram_read_q;
    assign bus.O_SRAM_WRITE     = sram_write_q;

    a_fifo_bound: assert property (@(posedge I_CLK) disable iff (I_RST)
        fifo_count <= CntW'(FIFO_DEPTH));
    a_one_strobe: assert property (@(posedge I_CLK) disable iff (I_RST)
        !(sram_read_q && sram_write_q));

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Randomised scoreboard bench for fb_sram_arbiter: per-cycle bus-owner rules, ordered write queue
// and fixed-latency read-return queue. Define PIX_CLIP_EN to expect clipping behaviour.
module tb_fb_sram_arbiter;
    import gpu_fb_pkg::*;

    localparam int unsigned Depth = 16;
`ifdef PIX_CLIP_EN
    localparam bit ClipEn = 1'b1;
`else
    localparam bit ClipEn = 1'b0;
`endif

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rd_t;

    logic clk = 1'b0;
    logic rst;

    fb_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_sram_arbiter #(.FIFO_DEPTH(Depth)) u_dut (
        .I_CLK (clk),
        .I_RST (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SRAM contents as seen by scan-out: a fixed pattern of the address.
    function automatic logic [DATA_W-1:0] sram_word(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    assign bus.I_SRAM_DATA = bus.O_SRAM_READ ? sram_word(bus.O_SRAM_ADDR) : '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_seen = 0;
    int wr_exp = 0;

    wr_t wq[$];
    rd_t rq[$];
    wr_t we;
    rd_t re;
    bit  rd_prev;
    logic [15:0] drop_exp;
    bit  exp_wr;
    bit  exp_vld;

    bit                have_pre = 1'b0;
    logic              pre_rst;
    logic              pre_rd;
    logic [ADDR_W-1:0] pre_vaddr;
    logic              pre_acc;
    logic [ADDR_W-1:0] pre_paddr;
    logic [DATA_W-1:0] pre_pdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: at each falling edge, account for the rising edge just passed using the inputs
    // latched at the previous falling edge.
    always @(negedge clk) begin
        if (have_pre) begin
            cyc++;
            if (pre_rst) begin
                wq.delete();
                rq.delete();
                rd_prev  = 1'b0;
                drop_exp = '0;
                chk("rst_sram_read", 64'(bus.O_SRAM_READ), 64'(0));
                chk("rst_sram_write", 64'(bus.O_SRAM_WRITE), 64'(0));
                chk("rst_sram_addr", 64'(bus.O_SRAM_ADDR), 64'(0));
                chk("rst_sram_data", 64'(bus.O_SRAM_DATA), 64'(0));
                chk("rst_vga_valid", 64'(bus.O_VGA_DATA_VALID), 64'(0));
                chk("rst_vga_data", 64'(bus.O_VGA_DATA), 64'(0));
                chk("rst_pix_ready", 64'(bus.O_PIX_READY), 64'(0));
                chk("rst_drop_cnt", 64'(bus.O_DROP_CNT), 64'(0));
            end else begin
                // Bus owner rule: read wins; a write needs a queued pixel and no read last cycle.
                exp_wr = !pre_rd && !rd_prev && (wq.size() > 0);
                chk("sram_read", 64'(bus.O_SRAM_READ), 64'(pre_rd));
                chk("sram_write", 64'(bus.O_SRAM_WRITE), 64'(exp_wr));
                if (pre_rd) chk("sram_read_addr", 64'(bus.O_SRAM_ADDR), 64'(pre_vaddr));
                if (bus.O_SRAM_WRITE) wr_seen++;
                if (exp_wr) begin
                    wr_exp++;
                    we = wq.pop_front();
                    chk("write_addr", 64'(bus.O_SRAM_ADDR), 64'(we.addr));
                    chk("write_data", 64'(bus.O_SRAM_DATA), 64'(we.data));
                end
                exp_vld = (rq.size() > 0) && (rq[0].due == cyc);
                chk("vga_valid", 64'(bus.O_VGA_DATA_VALID), 64'(exp_vld));
                if (exp_vld) begin
                    re = rq.pop_front();
                    chk("vga_data", 64'(bus.O_VGA_DATA), 64'(re.data));
                end
                if (pre_rd) rq.push_back('{data: sram_word(pre_vaddr), due: cyc + 1});
                if (pre_acc) begin
                    if (ClipEn && (32'(pre_paddr) >= FB_WORDS)) begin
                        if (drop_exp != 16'hFFFF) drop_exp = drop_exp + 16'd1;
                    end else begin
                        wq.push_back('{addr: pre_paddr, data: pre_pdata});
                    end
                end
                chk("pix_ready", 64'(bus.O_PIX_READY), 64'(wq.size() < Depth));
                chk("drop_cnt", 64'(bus.O_DROP_CNT), 64'(drop_exp));
                rd_prev = pre_rd;
            end
        end
        pre_rst   = rst;
        pre_rd    = bus.I_VGA_READ;
        pre_vaddr = bus.I_VGA_ADDR;
        pre_acc   = bus.I_PIX_VALID && bus.O_PIX_READY;
        pre_paddr = bus.I_PIX_ADDR;
        pre_pdata = bus.I_PIX_DATA;
        have_pre  = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pix(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int  n = 0;
        logic acc = 1'b0;
        bus.I_PIX_VALID = 1'b1;
        bus.I_PIX_ADDR  = a;
        bus.I_PIX_DATA  = d;
        while (!acc && (n < 200)) begin
            @(negedge clk);
            acc = bus.O_PIX_READY;
            tick();
            n++;
        end
        bus.I_PIX_VALID = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: addr 0x%0h not accepted within %0d cycles", a, n);
        end
    endtask

    task automatic read_burst(input int n, input logic [ADDR_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            bus.I_VGA_READ = 1'b1;
            bus.I_VGA_ADDR = base + ADDR_W'(i);
            tick();
        end
        bus.I_VGA_READ = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.I_PIX_VALID = 1'b0;
        bus.I_PIX_ADDR  = '0;
        bus.I_PIX_DATA  = '0;
        bus.I_VGA_READ  = 1'b0;
        bus.I_VGA_ADDR  = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Idle drain of four white pixels.
        for (int i = 0; i < 4; i++) push_pix(ADDR_W'(i), WHITE);
        repeat (8) tick();

        // Reads own the bus while two pixels wait.
        fork
            read_burst(5, ADDR_W'(100));
            begin
                push_pix(ADDR_W'(10), 16'h1234);
                push_pix(ADDR_W'(11), 16'h5678);
            end
        join
        repeat (8) tick();

        // Fill past capacity under continuous scan-out.
        fork
            read_burst(25, ADDR_W'(32'h10000));
            for (int i = 0; i < int'(Depth) + 3; i++) push_pix(ADDR_W'(i), DATA_W'($urandom));
        join
        repeat (25) tick();

        // One pixel per cycle with simultaneous push and pop.
        for (int i = 0; i < 20; i++) push_pix(ADDR_W'(20 + (i % 8)), DATA_W'($urandom));
        repeat (4) tick();

        // Clipping boundary.
        push_pix(ADDR_W'(FB_WORDS), BLUE);
        push_pix(ADDR_W'(5), BLUE);
        repeat (6) tick();
        chk("drop_cnt_clip", 64'(bus.O_DROP_CNT), ClipEn ? 64'(1) : 64'(0));

        // Random traffic with a mid-stream reset.
        for (int i = 0; i < 500; i++) begin
            bus.I_VGA_READ  = ($urandom_range(0, 2) == 0);
            bus.I_VGA_ADDR  = ADDR_W'(32'h10000 + $urandom_range(0, 32'hFFFF));
            bus.I_PIX_VALID = ($urandom_range(0, 1) == 1);
            bus.I_PIX_ADDR  = ($urandom_range(0, 15) == 0) ?
                              ADDR_W'(FB_WORDS + $urandom_range(0, 100)) :
                              ADDR_W'($urandom_range(0, 31));
            bus.I_PIX_DATA  = DATA_W'($urandom);
            rst = (i >= 250) && (i < 253);
            tick();
        end
        rst             = 1'b0;
        bus.I_VGA_READ  = 1'b0;
        bus.I_PIX_VALID = 1'b0;
        repeat (Depth + 10) tick();

        chk("total_writes", 64'(wr_seen), 64'(wr_exp));
        chk("end_pix_ready", 64'(bus.O_PIX_READY), 64'(1));
        chk("end_sram_idle", 64'(bus.O_SRAM_WRITE | bus.O_SRAM_READ), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
